// File: rtl/kalman_pkg.sv
// Shared types for the Kalman measurement feeder: default coordinate
// width, feeder FSM state encoding and the three-axis sample record.
package kalman_pkg;

  // Coordinate width used by vec3_t; must match kalman_fsm_3d.
  localparam int KF_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_START   = 2'd1,
    ST_RELEASE = 2'd2,
    ST_OUTPUT  = 2'd3
  } feeder_state_e;

  typedef struct packed {
    logic signed [KF_DATA_WIDTH-1:0] x;
    logic signed [KF_DATA_WIDTH-1:0] y;
    logic signed [KF_DATA_WIDTH-1:0] z;
  } vec3_t;

endpackage

// File: rtl/meas_fifo.sv
// Synchronous FIFO of measurement records with occupancy output.
// DEPTH must be a power of two (>= 2) so the pointers wrap for free.
module meas_fifo
  import kalman_pkg::*;
#(
  parameter int  DEPTH = 8,
  parameter type T     = vec3_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  T                       data_i,
  input  logic                   pop_i,
  output T                       data_o,
  output logic                   full_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  T              mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && (count_q != '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Sample storage.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; entries are only read after being written.
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/kalman_meas_feeder.sv
// Valid/ready adapter around kalman_fsm_3d: buffers camera samples,
// replays them one at a time through the start/done handshake and
// presents each filtered state downstream.
// Optional: define OUTLIER_GATE_EN to drop samples that jump more than
// MAX_JUMP from the last filtered state (count in drop_count).
// DATA_WIDTH must equal kalman_pkg::KF_DATA_WIDTH (vec3_t is packed).
module kalman_meas_feeder
  import kalman_pkg::*;
#(
  parameter int DATA_WIDTH     = KF_DATA_WIDTH,
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 64
`ifdef OUTLIER_GATE_EN
  ,
  parameter int MAX_JUMP       = 1000
`endif
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          meas_valid,
  output logic                          meas_ready,
  input  logic signed [DATA_WIDTH-1:0]  meas_x,
  input  logic signed [DATA_WIDTH-1:0]  meas_y,
  input  logic signed [DATA_WIDTH-1:0]  meas_z,
  output logic                          kf_start,
  output logic signed [DATA_WIDTH-1:0]  kf_z_x,
  output logic signed [DATA_WIDTH-1:0]  kf_z_y,
  output logic signed [DATA_WIDTH-1:0]  kf_z_z,
  input  logic                          kf_done,
  input  logic signed [DATA_WIDTH-1:0]  kf_x_x,
  input  logic signed [DATA_WIDTH-1:0]  kf_x_y,
  input  logic signed [DATA_WIDTH-1:0]  kf_x_z,
  output logic                          filt_valid,
  input  logic                          filt_ready,
  output logic signed [DATA_WIDTH-1:0]  filt_x,
  output logic signed [DATA_WIDTH-1:0]  filt_y,
  output logic signed [DATA_WIDTH-1:0]  filt_z,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          timeout_err
`ifdef OUTLIER_GATE_EN
  ,
  output logic [15:0]                   drop_count
`endif
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  feeder_state_e    state_q, state_d;
  vec3_t            kf_z_q, kf_z_d;
  vec3_t            filt_q, filt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;
  logic             discard_q, discard_d;
  logic             fifo_full;
  logic             fifo_pop;
  vec3_t            fifo_head;
  vec3_t            meas_vec;

`ifdef OUTLIER_GATE_EN
  logic        have_last_q, have_last_d;
  logic [15:0] drop_q, drop_d;
  logic        outlier;

  // True when |a - b| > MAX_JUMP; one extra bit keeps the difference exact.
  function automatic logic jump_exceeds(input logic signed [DATA_WIDTH-1:0] a,
                                        input logic signed [DATA_WIDTH-1:0] b);
    logic [DATA_WIDTH:0] diff;
    logic [DATA_WIDTH:0] mag;
    diff = {a[DATA_WIDTH-1], a} - {b[DATA_WIDTH-1], b};
    mag  = diff[DATA_WIDTH] ? -diff : diff;
    return mag > (DATA_WIDTH+1)'(MAX_JUMP);
  endfunction

  assign outlier = have_last_q &&
                   (jump_exceeds(fifo_head.x, filt_q.x) ||
                    jump_exceeds(fifo_head.y, filt_q.y) ||
                    jump_exceeds(fifo_head.z, filt_q.z));
  assign drop_count = drop_q;
`endif

  assign meas_vec   = '{x: meas_x, y: meas_y, z: meas_z};
  assign meas_ready = !fifo_full;

  meas_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (vec3_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (meas_valid && meas_ready),
    .data_i  (meas_vec),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .count_o (fifo_count)
  );

  // Next-state logic for the replay sequencer.
  always_comb begin
    // NOTE: every variable gets a default first so no latch is inferred.
    state_d   = state_q;
    kf_z_d    = kf_z_q;
    filt_d    = filt_q;
    tmo_d     = tmo_q;
    err_d     = err_q;
    discard_d = discard_q;
    fifo_pop  = 1'b0;
`ifdef OUTLIER_GATE_EN
    have_last_d = have_last_q;
    drop_d      = drop_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (fifo_count != '0) begin
          fifo_pop = 1'b1;
`ifdef OUTLIER_GATE_EN
          if (outlier) begin
            drop_d = (drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1;
          end else begin
            kf_z_d    = fifo_head;
            tmo_d     = '0;
            discard_d = 1'b0;
            state_d   = ST_START;
          end
`else
          kf_z_d    = fifo_head;
          tmo_d     = '0;
          discard_d = 1'b0;
          state_d   = ST_START;
`endif
        end
      end
      ST_START: begin
        tmo_d = tmo_q + TMO_W'(1);
        if (kf_done) begin
          filt_d  = '{x: kf_x_x, y: kf_x_y, z: kf_x_z};
          state_d = ST_RELEASE;
`ifdef OUTLIER_GATE_EN
          have_last_d = 1'b1;
`endif
        end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          err_d     = 1'b1;
          discard_d = 1'b1;
          state_d   = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (!kf_done) state_d = discard_q ? ST_IDLE : ST_OUTPUT;
      end
      ST_OUTPUT: begin
        if (filt_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer registers; reset returns everything to idle at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      kf_z_q    <= '0;
      filt_q    <= '0;
      tmo_q     <= '0;
      err_q     <= 1'b0;
      discard_q <= 1'b0;
`ifdef OUTLIER_GATE_EN
      have_last_q <= 1'b0;
      drop_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      kf_z_q    <= kf_z_d;
      filt_q    <= filt_d;
      tmo_q     <= tmo_d;
      err_q     <= err_d;
      discard_q <= discard_d;
`ifdef OUTLIER_GATE_EN
      have_last_q <= have_last_d;
      drop_q      <= drop_d;
`endif
    end
  end

  assign kf_start    = (state_q == ST_START);
  assign filt_valid  = (state_q == ST_OUTPUT);
  assign kf_z_x      = kf_z_q.x;
  assign kf_z_y      = kf_z_q.y;
  assign kf_z_z      = kf_z_q.z;
  assign filt_x      = filt_q.x;
  assign filt_y      = filt_q.y;
  assign filt_z      = filt_q.z;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_kalman_meas_feeder.sv
// Self-checking bench for kalman_meas_feeder with a behavioural filter
// that raises done 5 cycles after start and returns (9*z)/10 per axis.
module tb_kalman_meas_feeder;

  localparam int DONE_LAT = 5;

  typedef struct {
    int x, y, z;
    int ex, ey, ez;
  } vec_t;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               meas_valid = 1'b0;
  logic               meas_ready;
  logic signed [31:0] meas_x = '0, meas_y = '0, meas_z = '0;
  logic               kf_start;
  logic signed [31:0] kf_z_x, kf_z_y, kf_z_z;
  logic               kf_done;
  logic signed [31:0] kf_x_x, kf_x_y, kf_x_z;
  logic               filt_valid;
  logic               filt_ready = 1'b0;
  logic signed [31:0] filt_x, filt_y, filt_z;
  logic [3:0]         fifo_count;
  logic               timeout_err;
`ifdef OUTLIER_GATE_EN
  logic [15:0]        drop_count;
`endif

  int passed = 0;
  int total  = 0;
  int start_rises = 0;
  logic start_prev = 1'b0;
  logic hang = 1'b0;
  int   mcnt;

  kalman_meas_feeder dut (
    .clk        (clk),
    .rst        (rst),
    .meas_valid (meas_valid),
    .meas_ready (meas_ready),
    .meas_x     (meas_x),
    .meas_y     (meas_y),
    .meas_z     (meas_z),
    .kf_start   (kf_start),
    .kf_z_x     (kf_z_x),
    .kf_z_y     (kf_z_y),
    .kf_z_z     (kf_z_z),
    .kf_done    (kf_done),
    .kf_x_x     (kf_x_x),
    .kf_x_y     (kf_x_y),
    .kf_x_z     (kf_x_z),
    .filt_valid (filt_valid),
    .filt_ready (filt_ready),
    .filt_x     (filt_x),
    .filt_y     (filt_y),
    .filt_z     (filt_z),
    .fifo_count (fifo_count),
    .timeout_err(timeout_err)
`ifdef OUTLIER_GATE_EN
    ,
    .drop_count (drop_count)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural filter: done after DONE_LAT cycles of start, held until start drops.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      kf_done <= 1'b0;
      mcnt    <= 0;
      kf_x_x  <= '0;
      kf_x_y  <= '0;
      kf_x_z  <= '0;
    end else if (!kf_start) begin
      kf_done <= 1'b0;
      mcnt    <= 0;
    end else if (!kf_done && !hang) begin
      if (mcnt == DONE_LAT - 1) begin
        kf_done <= 1'b1;
        kf_x_x  <= (kf_z_x * 9) / 10;
        kf_x_y  <= (kf_z_y * 9) / 10;
        kf_x_z  <= (kf_z_z * 9) / 10;
      end
      mcnt <= mcnt + 1;
    end
  end

  // Count kf_start rising edges.
  always @(posedge clk) begin
    start_prev <= kf_start;
    if (kf_start && !start_prev) start_rises <= start_rises + 1;
  end

  task automatic check(input string nm, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic push1(input int x, input int y, input int z);
    @(negedge clk);
    meas_valid = 1'b1;
    meas_x = x; meas_y = y; meas_z = z;
    @(posedge clk);
    #1 meas_valid = 1'b0;
  endtask

  task automatic wait_filt(input string nm, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (filt_valid) begin ok = 1'b1; break; end
    end
    if (!ok) check({nm, "_wait_filt_timeout"}, 0, 1);
  endtask

  task automatic wait_start(input string nm, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (kf_start) begin ok = 1'b1; break; end
    end
    if (!ok) check({nm, "_wait_start_timeout"}, 0, 1);
  endtask

  vec_t burst [8];

  initial begin
    bit ok;
    bit stable;
    int r0;
    int waited;

    burst[0] = '{10,  -10,  100,  9,  -9,  90};
    burst[1] = '{20,  -20, -100, 18, -18, -90};
    burst[2] = '{30,  -30,  100, 27, -27,  90};
    burst[3] = '{40,  -40, -100, 36, -36, -90};
    burst[4] = '{50,  -50,  100, 45, -45,  90};
    burst[5] = '{60,  -60, -100, 54, -54, -90};
    burst[6] = '{70,  -70,  100, 63, -63,  90};
    burst[7] = '{80,  -80, -100, 72, -72, -90};

    // Reset state
    #12;
    check("rst_meas_ready", meas_ready, 1);
    check("rst_kf_start", kf_start, 0);
    check("rst_filt_valid", filt_valid, 0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_kf_z_x", kf_z_x, 0);
    check("rst_filt_x", filt_x, 0);
    @(negedge clk);
    rst = 1'b0;

    // Single sample with latency checks
    push1(100, -50, 7);
    @(negedge clk);
    check("single_count_after_push", fifo_count, 1);
    check("single_no_start_yet", kf_start, 0);
    @(negedge clk);
    check("single_start_after_pop", kf_start, 1);
    check("single_count_popped", fifo_count, 0);
    waited = 0;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      if (kf_done) begin waited = c; break; end
    end
    check("single_done_latency", waited, DONE_LAT);
    check("single_start_at_done", kf_start, 1);
    check("single_kf_z_x", kf_z_x, 100);
    check("single_kf_z_y", kf_z_y, -50);
    check("single_kf_z_z", kf_z_z, 7);
    @(negedge clk);
    check("single_start_dropped", kf_start, 0);
    check("single_done_still_high", kf_done, 1);
    @(negedge clk);
    check("single_done_fell", kf_done, 0);
    check("single_valid_not_yet", filt_valid, 0);
    @(negedge clk);
    check("single_filt_valid", filt_valid, 1);
    check("single_filt_x", filt_x, 90);
    check("single_filt_y", filt_y, -45);
    check("single_filt_z", filt_z, 6);
    filt_ready = 1'b1;
    @(negedge clk);
    check("single_accepted", filt_valid, 0);

    // Backpressure with a burst arriving while the output is held
    filt_ready = 1'b0;
    push1(-1000, 2000, 3);
    wait_filt("bp", ok);
    check("bp_filt_x", filt_x, -900);
    check("bp_filt_y", filt_y, 1800);
    check("bp_filt_z", filt_z, 2);
    r0 = start_rises;
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) @(negedge clk);
      if (!(filt_valid && filt_x == -900 && filt_y == 1800 && filt_z == 2)) stable = 1'b0;
      if (i == 8) begin
        check("burst_full_count", fifo_count, 8);
        check("burst_full_ready", meas_ready, 0);
      end
      if (i == 10) check("burst_overflow_rejected", fifo_count, 8);
      if (i < 8) begin
        meas_valid = 1'b1;
        meas_x = burst[i].x; meas_y = burst[i].y; meas_z = burst[i].z;
      end else if (i < 10) begin
        meas_valid = 1'b1;
        meas_x = 999; meas_y = 999; meas_z = 999;
      end else begin
        meas_valid = 1'b0;
      end
    end
    @(negedge clk);
    check("bp_filt_stable", stable, 1);
    check("bp_no_new_start", start_rises - r0, 0);
    filt_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      wait_filt("burst", ok);
      if (ok) begin
        check($sformatf("burst%0d_x", j), filt_x, burst[j].ex);
        check($sformatf("burst%0d_y", j), filt_y, burst[j].ey);
        check($sformatf("burst%0d_z", j), filt_z, burst[j].ez);
      end
    end
    @(negedge clk);
    check("burst_drained", fifo_count, 0);
    check("burst_start_count", start_rises - r0, 8);

    // Timeout: filter never answers
    hang = 1'b1;
    push1(1, 2, 3);
    wait_start("tmo", ok);
    stable = 1'b1;
    for (int k = 1; k < 64; k++) begin
      @(negedge clk);
      if (!(kf_start && !timeout_err)) stable = 1'b0;
    end
    check("tmo_start_held_63", stable, 1);
    @(negedge clk);
    check("tmo_err_set", timeout_err, 1);
    check("tmo_start_dropped", kf_start, 0);
    stable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (filt_valid) stable = 1'b0;
    end
    check("tmo_no_filt_valid", stable, 1);
    hang = 1'b0;
    push1(-20, 30, 0);
    wait_filt("tmo_next", ok);
    check("tmo_next_x", filt_x, -18);
    check("tmo_next_y", filt_y, 27);
    check("tmo_next_z", filt_z, 0);
    check("tmo_err_sticky", timeout_err, 1);

    // Reset mid-flight with 3 entries queued
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      meas_valid = 1'b1;
      meas_x = i + 1; meas_y = i + 1; meas_z = i + 1;
    end
    @(negedge clk);
    meas_valid = 1'b0;
    check("mid_in_start", kf_start, 1);
    check("mid_queued", fifo_count, 3);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_start", kf_start, 0);
    check("mid_rst_count", fifo_count, 0);
    check("mid_rst_ready", meas_ready, 1);
    check("mid_rst_err", timeout_err, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mid_after_count", fifo_count, 0);
    check("mid_after_valid", filt_valid, 0);

`ifdef OUTLIER_GATE_EN
    // Outlier gating
    push1(0, 0, 0);
    wait_filt("gate_first", ok);
    check("gate_first_x", filt_x, 0);
    r0 = start_rises;
    push1(5000, 0, 0);
    for (int k = 0; k < 10; k++) @(negedge clk);
    check("gate_no_start", start_rises - r0, 0);
    check("gate_drop_count", drop_count, 1);
    check("gate_count_empty", fifo_count, 0);
    push1(900, 0, 0);
    wait_filt("gate_pass", ok);
    check("gate_pass_x", filt_x, 810);
    check("gate_drop_unchanged", drop_count, 1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
